// File: rtl/ram_ctrl_param_if.sv
//==============================================================================
// Interface : ram_ctrl_param_if
// Brief     : User-side bus of ram_ctrl_param (access, clear/scan control, read result).
// Revision  : 1.0 - initial release
//==============================================================================
`default_nettype none

interface ram_ctrl_param_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic              clear;
  logic              scan_en;
  logic              busy;
  logic [DATA_W-1:0] q;
  logic [ADDR_W-1:0] q_addr;
  logic              q_valid;
  logic              parity_err;

  modport master (
    output address, data, wren, clear, scan_en,
    input  busy, q, q_addr, q_valid, parity_err
  );

  modport slave (
    input  address, data, wren, clear, scan_en,
    output busy, q, q_addr, q_valid, parity_err
  );
endinterface

`default_nettype wire

// File: rtl/ram_ctrl_param.sv
//==============================================================================
// Module   : ram_ctrl_param
// Brief    : Parametrised single-port synchronous RAM controller with a clear
//            engine and an auto-scan read mode. Optional parity storage is
//            enabled by defining RAM_PARITY_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ram_ctrl_param #(
  parameter int                DATA_W    = 4,
  parameter int                ADDR_W    = 5,
  parameter int                DEPTH     = 32,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
  parameter int                SCAN_DIV  = 4
) (
  input logic             clock,
  input logic             resetn,
  ram_ctrl_param_if.slave bus
);

  localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);

`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_SCAN  = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] clear_ptr;
  logic [ADDR_W-1:0] scan_ptr;
  logic [DIV_W-1:0]  div_cnt;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ok;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ok;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rd_word;

  logic [MEM_W-1:0]  mem [DEPTH];

  logic [DATA_W-1:0] rd_q;
  logic [ADDR_W-1:0] rd_q_addr;
  logic              rd_valid;

  // Next-state and datapath steering
  always_comb begin
    next_state = state;
    rd_en      = 1'b0;
    rd_addr    = bus.address;
    wr_en      = 1'b0;
    wr_addr    = bus.address;
    wr_data    = bus.data;
    case (state)
      S_IDLE: begin
        rd_en = 1'b1;
        wr_en = bus.wren;
        if (bus.clear) begin
          next_state = S_CLEAR;
        end else if (bus.scan_en) begin
          next_state = S_SCAN;
        end
      end
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clear_ptr;
        wr_data = CLEAR_VAL;
        if (clear_ptr == LAST_ADDR) begin
          next_state = S_IDLE;
        end
      end
      S_SCAN: begin
        rd_en   = (div_cnt == '0);
        rd_addr = scan_ptr;
        if (bus.clear) begin
          next_state = S_CLEAR;
        end else if (!bus.scan_en) begin
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      clear_ptr <= '0;
      scan_ptr  <= '0;
      div_cnt   <= '0;
    end else begin
      state <= next_state;
      if (state == S_CLEAR && next_state == S_CLEAR) begin
        clear_ptr <= clear_ptr + ADDR_W'(1);
      end else begin
        clear_ptr <= '0;
      end
      // Counters restart from zero on every entry into SCAN
      if (state == S_SCAN && next_state == S_SCAN) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt  <= '0;
          scan_ptr <= (scan_ptr == LAST_ADDR) ? '0 : scan_ptr + ADDR_W'(1);
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end else begin
        div_cnt  <= '0;
        scan_ptr <= '0;
      end
    end
  end

  if (DEPTH == (1 << ADDR_W)) begin : g_full_range
    assign rd_ok = 1'b1;
    assign wr_ok = wr_en;
  end else begin : g_partial_range
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    assign rd_ok = ({1'b0, rd_addr} < DEPTH_LIM);
    assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_LIM);
  end

`ifdef RAM_PARITY_EN
  assign wr_word = {^wr_data, wr_data};
`else
  assign wr_word = wr_data;
`endif

  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_word;
    end
  end

  // Out-of-range reads return zero; same-edge writes leave the old word visible
  assign rd_word = rd_ok ? mem[rd_addr] : '0;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_q      <= '0;
      rd_q_addr <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_q      <= rd_word[DATA_W-1:0];
        rd_q_addr <= rd_addr;
      end
    end
  end

`ifdef RAM_PARITY_EN
  logic rd_perr;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_perr <= 1'b0;
    end else begin
      rd_perr <= rd_en && rd_ok && (^rd_word);
    end
  end

  assign bus.parity_err = rd_perr;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.busy    = (state == S_CLEAR);
  assign bus.q       = rd_q;
  assign bus.q_addr  = rd_q_addr;
  assign bus.q_valid = rd_valid;

endmodule

`default_nettype wire
